// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit processor: opcodes, sequencer states,
// datapath widths and instruction field positions.
package cpu_pkg;

    localparam int DATA_W    = 4;
    localparam int PC_W      = 4;
    localparam int INSTR_W   = 12;
    localparam int REG_IDX_W = 2;

    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 9;
    localparam int R0_MSB  = 8;
    localparam int R0_LSB  = 7;
    localparam int R1_MSB  = 6;
    localparam int R1_LSB  = 5;
    localparam int R2_MSB  = 4;
    localparam int R2_LSB  = 3;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_LOAD  = 3'b010,
        OP_STORE = 3'b011,
        OP_JEQ   = 3'b100,
        OP_LDI   = 3'b101,
        OP_NOP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALTED
    } cu_state_t;

    // Operand reads for ADD/SUB come from r1/r2; JEQ and STORE compare or store r0/r1.
    function automatic logic uses_r1_r2(opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction ROM, ALU and data-memory bus between the sequencer and its neighbours.
interface control_unit_if;
    import cpu_pkg::*;

    logic [PC_W-1:0]    instr_addr;
    logic [INSTR_W-1:0] instr_data;
    logic [DATA_W-1:0]  ALU_src1;
    logic [DATA_W-1:0]  ALU_src2;
    logic               ALU_op;
    logic [DATA_W-1:0]  ALU_out;
    logic               EQ;
    logic [DATA_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_we;
    logic [DATA_W-1:0]  dmem_rdata;

    modport master (
        output instr_addr, ALU_src1, ALU_src2, ALU_op, dmem_addr, dmem_wdata, dmem_we,
        input  instr_data, ALU_out, EQ, dmem_rdata
    );

    modport slave (
        input  instr_addr, ALU_src1, ALU_src2, ALU_op, dmem_addr, dmem_wdata, dmem_we,
        output instr_data, ALU_out, EQ, dmem_rdata
    );

endinterface

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one synchronous write port,
// synchronous active-high reset clearing every entry.
module reg_file
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata1,
    output logic [DATA_W-1:0]    rdata2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer (FETCH/DECODE/EXECUTE/WRITEBACK) for the 4-bit processor.
// Define CU_LDI_EN to make opcode 101 load its immediate; otherwise it is a NOP.
module control_unit
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int PC_W     = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           halted,
    output logic           busy,
    control_unit_if.master bus
);

    cu_state_t              state;
    logic [PC_W-1:0]        pc;
    logic [INSTR_W-1:0]     ir;
    logic [DATA_W-1:0]      a_q;
    logic [DATA_W-1:0]      b_q;
    logic [DATA_W-1:0]      r_q;
    logic                   eq_q;
    logic                   dmem_we_q;

    opcode_t                op;
    logic [REG_IDX_W-1:0]   r0_idx;
    logic [REG_IDX_W-1:0]   r1_idx;
    logic [REG_IDX_W-1:0]   r2_idx;
    logic [DATA_W-1:0]      imm;
    logic [REG_IDX_W-1:0]   rd_idx1;
    logic [REG_IDX_W-1:0]   rd_idx2;
    logic [DATA_W-1:0]      rd_data1;
    logic [DATA_W-1:0]      rd_data2;
    logic                   wb_en;
    logic                   rf_we;
    logic [PC_W-1:0]        pc_next;

    assign op      = opcode_t'(ir[OPC_MSB:OPC_LSB]);
    assign r0_idx  = ir[R0_MSB:R0_LSB];
    assign r1_idx  = ir[R1_MSB:R1_LSB];
    assign r2_idx  = ir[R2_MSB:R2_LSB];
    assign imm     = ir[IMM_MSB:IMM_LSB];

    assign rd_idx1 = uses_r1_r2(op) ? r1_idx : r0_idx;
    assign rd_idx2 = uses_r1_r2(op) ? r2_idx : r1_idx;

    always_comb begin
        wb_en = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_LOAD: wb_en = 1'b1;
`ifdef CU_LDI_EN
            OP_LDI:                  wb_en = 1'b1;
`endif
            default:                 wb_en = 1'b0;
        endcase
    end

    assign rf_we   = (state == WRITEBACK) && wb_en;
    assign pc_next = (op == OP_JEQ && eq_q) ? PC_W'(imm) : pc + 1'b1;

    reg_file #(.NUM_REGS(NUM_REGS)) u_rf (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rd_idx1),
        .raddr2 (rd_idx2),
        .rdata1 (rd_data1),
        .rdata2 (rd_data2),
        .we     (rf_we),
        .waddr  (r0_idx),
        .wdata  (r_q)
    );

    // The STORE strobe is raised on entry to EXECUTE so it covers exactly that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            eq_q      <= 1'b0;
            dmem_we_q <= 1'b0;
            halted    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        pc    <= '0;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    ir    <= bus.instr_data;
                    state <= DECODE;
                end
                DECODE: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_JEQ, OP_STORE: begin
                            a_q <= rd_data1;
                            b_q <= rd_data2;
                        end
                        default: ;
                    endcase
                    dmem_we_q <= (op == OP_STORE);
                    state     <= EXECUTE;
                end
                EXECUTE: begin
                    dmem_we_q <= 1'b0;
                    eq_q      <= bus.EQ;
                    case (op)
                        OP_ADD, OP_SUB: r_q <= bus.ALU_out;
                        OP_LOAD:        r_q <= bus.dmem_rdata;
`ifdef CU_LDI_EN
                        OP_LDI:         r_q <= imm;
`endif
                        default: ;
                    endcase
                    if (op == OP_HALT) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    pc    <= pc_next;
                    state <= FETCH;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr_addr = pc;
    assign bus.ALU_src1   = a_q;
    assign bus.ALU_src2   = b_q;
    assign bus.ALU_op     = (op == OP_ADD);
    assign bus.dmem_addr  = ir[IMM_MSB:IMM_LSB];
    assign bus.dmem_wdata = a_q;
    assign bus.dmem_we    = dmem_we_q;

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 4-bit processor; sits directly upstream of the ALU. Fetches 12-bit instructions from an external asynchronous instruction ROM, reads operands from an internal 4×4-bit register file, and drives the ALU sources and op. It consumes the ALU result and `EQ` flag for write-back and conditional jumps, and drives a small external data memory.

## Interface
Parameters:
- `NUM_REGS`, 4: register-file depth; index width is 2, fixed.
- `PC_W`, 4: program-counter width; 16 instructions.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: leaves IDLE when sampled high.
- `instr_addr` out 4: equals PC.
- `instr_data` in 12: combinational ROM data for `instr_addr`.
- `ALU_src1`, `ALU_src2` out 4: operand registers A and B.
- `ALU_op` out 1: 1 = add, 0 = subtract.
- `ALU_out` in 4: ALU result.
- `EQ` in 1: ALU equality flag.
- `dmem_addr` out 4: data-memory address.
- `dmem_wdata` out 4: store data.
- `dmem_we` out 1: one-cycle write strobe.
- `dmem_rdata` in 4: combinational read data.
- `halted` out 1: high in HALTED.
- `busy` out 1: high in FETCH, DECODE, EXECUTE and WRITEBACK.

## Operation
- Instruction fields: opcode [11:9], r0 [8:7], r1 [6:5], r2 [4:3], imm/addr [3:0].
- ADD 000: r0 = r1 + r2.
- SUB 001: r0 = r1 − r2.
- LOAD 010: r0 = mem[addr].
- STORE 011: mem[addr] = r0.
- JEQ 100: if r0 == r1 then PC = addr, else PC + 1.
- LDI 101: r0 = imm; see Configuration.
- 110: NOP.
- HALT 111.
- States: IDLE → FETCH → DECODE → EXECUTE → WRITEBACK → FETCH. HALT goes to HALTED.
- IDLE: waits for `start`.
- FETCH: IR <= `instr_data`.
- DECODE: for ADD/SUB, A <= reg[r1] and B <= reg[r2]. For JEQ and STORE, A <= reg[r0] and B <= reg[r1]. Otherwise A and B hold their values.
- EXECUTE:
  - Capture R <= `ALU_out` (ADD/SUB), `dmem_rdata` (LOAD) or imm (LDI).
  - Capture EQ_q <= `EQ`.
  - STORE: `dmem_we` = 1.
  - HALT: next state is HALTED, with no WRITEBACK.
- WRITEBACK:
  - ADD, SUB, LOAD and LDI write reg[r0] <= R.
  - PC <= addr if JEQ && EQ_q; otherwise PC + 1, wrapping 15 → 0.
- HALTED: absorbing; only `reset` leaves it. `start` is ignored.
- Arithmetic is 4-bit modulo (ALU wraps). No carry or overflow is kept.
- `ALU_op` is decoded combinationally from IR: 1 for ADD, 0 for all other opcodes.
- `dmem_addr` = IR[3:0] and `dmem_wdata` = A, combinationally.
- `start` is ignored outside IDLE.
- A register write to r0 in WRITEBACK is visible to the next instruction's DECODE.

## Timing
- Every non-HALT instruction takes 4 cycles; throughput is 1 instruction per 4 cycles. HALT takes 3 cycles to reach HALTED.
- `start` sampled in IDLE at edge N puts the FSM in FETCH from N+1, with PC = 0.
- `ALU_src1`, `ALU_src2` and `ALU_op` are stable throughout EXECUTE. ALU results are sampled only at the end of EXECUTE.
- `dmem_we` is high for exactly one cycle (EXECUTE) per STORE and 0 at all other times.
- Reset values: state = IDLE; PC, IR, A, B, R and EQ_q = 0; all registers = 0; `dmem_we`, `halted` and `busy` = 0; `ALU_op` = 1 (IR = 0 decodes as ADD).
- Reset asserted in any state, mid-instruction included, takes effect at the next edge. It aborts a pending write-back, and any STORE strobe ends with the reset edge.

## Configuration
- `CU_LDI_EN` defined: opcode 101 is LDI as specified.
- Not defined: opcode 101 behaves as NOP, with no register write and PC + 1.

## Structure
- Shared package `cpu_pkg` holds:
  - `opcode_t` enum, 3-bit.
  - `cu_state_t` enum: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
  - Localparams `DATA_W` = 4, `PC_W` = 4, `INSTR_W` = 12, `REG_IDX_W` = 2.
  - Field-position constants.
- Sub-module `reg_file`:
  - `NUM_REGS` × `DATA_W`.
  - Two combinational read ports and one synchronous write port (`we`, `waddr`, `wdata`).
  - Synchronous active-high reset clears all entries to 0.

## Test plan
- Reset then `start`; ROM: LDI r1,5; LDI r2,3; ADD r0,r1,r2; HALT → r0 = 8, `halted` = 1 after 15 cycles, PC frozen at 3.
- SUB wrap: r1 = 2, r2 = 5, SUB r3,r1,r2 → r3 = 13; `ALU_op` = 0 throughout EXECUTE.
- JEQ taken and not taken: r0 = r1 = 7, JEQ r0,r1,9 → PC = 9. With r1 = 6 → PC = old PC + 1. PC at 15 with a non-jump wraps to 0.
- STORE r2 to addr 4, then LOAD r3 from 4 with a model memory → `dmem_we` is a single-cycle pulse with addr 4 and data = r2; r3 equals r2.
- Reset asserted during EXECUTE of a STORE → `dmem_we` low after that edge, state IDLE, all registers 0, no write-back.
- Build without `CU_LDI_EN`: LDI r1,5 → r1 stays 0 and PC increments.
